move_input_conditioner: RTL and testbench

Upstream of the player stage. Conditions the four raw direction pushbuttons: synchronises, debounces, rejects multi-key chords and generates auto-repeat. Delivers one-hot move commands to the player over a valid/ready handshake. The player asserts ready once it has finished its wall-collision lookup.

---
 rtl/move_input_conditioner.sv | 185 ++++++++++++++++++
 tb/tb_move_input_conditioner.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/move_input_conditioner.sv
// move_input_conditioner: turns the four raw direction buttons into one-hot
// move commands for the player stage. The buttons are synchronised and
// debounced, chords are rejected and held keys auto-repeat. Commands go out
// through a single-entry valid/ready buffer.
// Build option: define REPEAT_EN for auto-repeat (DELAY/REPEAT states).
// Without it a press gives exactly one command (single HELD state).
module move_input_conditioner #(
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int CNT_W           = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] mov_raw,
    input  logic       en,
    output logic       cmd_valid,
    output logic [3:0] cmd_dir,
    input  logic       cmd_ready,
    output logic [3:0] pressed
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Configurations whose counts do not fit in CNT_W bits are illegal; this
    // empty block only marks that case during elaboration.
    if ((DEBOUNCE_CYCLES > 2**CNT_W) || (REPEAT_DELAY > 2**CNT_W) ||
        (REPEAT_PERIOD > 2**CNT_W)) begin : g_cnt_w_too_small
    end

    logic [3:0]            sampled;
    logic [3:0]            sync1;
    logic [3:0]            sync2;
    logic [3:0][CNT_W-1:0] db_cnt;
    logic [3:0]            held_dir;
    logic                  issue;

`ifdef REPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
    logic [CNT_W-1:0] rpt_cnt;
`else
    typedef enum logic [1:0] {IDLE, HELD} state_t;
`endif

    state_t state;

    assign sampled = (ACTIVE_LOW != 0) ? ~mov_raw : mov_raw;

    // Two-flop synchroniser, one chain per button; reset means released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sampled;
            sync2 <= sync1;
        end
    end

    // Per-button debounce: a new level must be seen for DEBOUNCE_CYCLES
    // consecutive cycles before it is accepted; any return to the current
    // level throws away the count collected so far.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pressed <= '0;
            db_cnt  <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == pressed[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    pressed[i] <= sync2[i];
                    db_cnt[i]  <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Issue event: a fresh one-hot press, or a repeat point of the key
    // still held; en only gates the event, never the state tracking.
    always_comb begin
        issue = 1'b0;
        case (state)
            IDLE:    issue = en && $onehot(pressed);
`ifdef REPEAT_EN
            DELAY:   issue = en && (pressed == held_dir) && (rpt_cnt == DELAY_LAST);
            REPEAT:  issue = en && (pressed == held_dir) && (rpt_cnt == PERIOD_LAST);
`endif
            default: issue = 1'b0;
        endcase
    end

`ifdef REPEAT_EN
    // Key-hold FSM: any change of pressed drops back to IDLE, so switching
    // keys always costs one cycle before the new key issues.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            held_dir <= '0;
            rpt_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rpt_cnt <= '0;
                    if ($onehot(pressed)) begin
                        held_dir <= pressed;
                        state    <= DELAY;
                    end
                end
                DELAY: begin
                    if (pressed != held_dir) begin
                        state   <= IDLE;
                        rpt_cnt <= '0;
                    end else if (rpt_cnt == DELAY_LAST) begin
                        state   <= REPEAT;
                        rpt_cnt <= '0;
                    end else begin
                        rpt_cnt <= rpt_cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (pressed != held_dir) begin
                        state   <= IDLE;
                        rpt_cnt <= '0;
                    end else if (rpt_cnt == PERIOD_LAST) begin
                        rpt_cnt <= '0;
                    end else begin
                        rpt_cnt <= rpt_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rpt_cnt <= '0;
                end
            endcase
        end
    end
`else
    // Key-hold FSM without repeat: one command per press, HELD waits for
    // pressed to change before another press can issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            held_dir <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if ($onehot(pressed)) begin
                        held_dir <= pressed;
                        state    <= HELD;
                    end
                end
                HELD: begin
                    if (pressed != held_dir) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

    // Single-entry command buffer: load when empty or being drained this
    // cycle, otherwise drop the event; clear to zero once accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_valid <= 1'b0;
            cmd_dir   <= '0;
        end else if (issue && (!cmd_valid || cmd_ready)) begin
            cmd_valid <= 1'b1;
            cmd_dir   <= pressed;
        end else if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
            cmd_dir   <= '0;
        end
    end

endmodule

// File: tb/tb_move_input_conditioner.sv
// tb_move_input_conditioner: directed scenarios followed by random button
// traffic, every cycle compared against a behavioural model of the
// conditioner (debounce window, key hold age, one-entry buffer).
// Honours REPEAT_EN the same way as the design.
module tb_move_input_conditioner;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] mov_raw = 4'b1111;
    logic       en = 1'b1;
    logic       cmd_ready = 1'b1;
    logic       cmd_valid;
    logic [3:0] cmd_dir;
    logic [3:0] pressed;

    int pass_count = 0;
    int check_count = 0;

    // Model state
    logic [3:0] m_s1, m_s2, m_pressed, m_held, m_dir;
    logic       m_valid;
    int         m_age;
    logic [3:0] m_win[$];

    move_input_conditioner #(
        .ACTIVE_LOW(1),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP),
        .CNT_W(25)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mov_raw(mov_raw),
        .en(en),
        .cmd_valid(cmd_valid),
        .cmd_dir(cmd_dir),
        .cmd_ready(cmd_ready),
        .pressed(pressed)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_s1 = '0;
        m_s2 = '0;
        m_pressed = '0;
        m_held = '0;
        m_dir = '0;
        m_valid = 1'b0;
        m_age = 0;
        m_win.delete();
    endtask

    // One clock edge of the reference behaviour, using pre-edge values.
    task automatic model_edge();
        logic       ev;
        logic [3:0] ev_dir;
        logic       acc;
        logic       flip;
        if (!rst) begin
            model_reset();
            return;
        end
        // m_held == 0 stands for "no key being tracked"
        ev = 1'b0;
        ev_dir = m_pressed;
        if (m_held == 4'b0000) begin
            if ($onehot(m_pressed)) begin
                ev = en;
                m_held = m_pressed;
                m_age = 0;
            end
        end else if (m_pressed != m_held) begin
            m_held = 4'b0000;
        end else begin
            m_age++;
`ifdef REPEAT_EN
            ev = en && ((m_age == RD) || ((m_age > RD) && (((m_age - RD) % RP) == 0)));
`endif
        end
        acc = m_valid && cmd_ready;
        if (ev && (!m_valid || acc)) begin
            m_valid = 1'b1;
            m_dir = ev_dir;
        end else if (acc) begin
            m_valid = 1'b0;
            m_dir = 4'b0000;
        end
        // A level is accepted once the last DB synchronised samples all differ
        m_win.push_back(m_s2);
        if (m_win.size() > DB) void'(m_win.pop_front());
        if (m_win.size() == DB) begin
            for (int b = 0; b < 4; b++) begin
                flip = 1'b1;
                for (int k = 0; k < DB; k++)
                    if (m_win[k][b] == m_pressed[b]) flip = 1'b0;
                if (flip) m_pressed[b] = ~m_pressed[b];
            end
        end
        m_s2 = m_s1;
        m_s1 = ~mov_raw;
    endtask

    task automatic check_value(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        check_count++;
        assert (obs === exp) pass_count++;
        else $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    endtask

    task automatic checkOutput();
        check_value("cmd_valid", {3'b000, cmd_valid}, {3'b000, m_valid});
        check_value("cmd_dir", cmd_dir, m_dir);
        check_value("pressed", pressed, m_pressed);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        checkOutput();
    endtask

    task automatic applyStimulus(input logic [3:0] raw, input logic en_v,
                                 input logic ready_v, input int cycles);
        mov_raw = raw;
        en = en_v;
        cmd_ready = ready_v;
        for (int i = 0; i < cycles; i++) tick();
    endtask

    int pulses;
    logic [3:0] rnd_raw;
    int rnd_len;

    initial begin
        model_reset();
        // Power-on reset
        applyStimulus(4'b1111, 1'b1, 1'b1, 3);
        check_value("reset_valid", {3'b000, cmd_valid}, 4'b0000);
        check_value("reset_pressed", pressed, 4'b0000);
        rst = 1'b1;
        applyStimulus(4'b1111, 1'b1, 1'b1, 10);

        // Reset mid-press: command 7 edges after release
        $display("[TB] reset mid-press");
        applyStimulus(4'b1110, 1'b1, 1'b1, 30);
        rst = 1'b0;
        model_reset();
        #1;
        check_value("rst_async_valid", {3'b000, cmd_valid}, 4'b0000);
        check_value("rst_async_pressed", pressed, 4'b0000);
        tick();
        rst = 1'b1;
        applyStimulus(4'b1110, 1'b1, 1'b1, 6);
        check_value("rst_latency_early", {3'b000, cmd_valid}, 4'b0000);
        tick();
        check_value("rst_latency_valid", {3'b000, cmd_valid}, 4'b0001);
        check_value("rst_latency_dir", cmd_dir, 4'b0001);
        applyStimulus(4'b1111, 1'b1, 1'b1, 20);

        // Debounce: glitch rejected, then exact latency
        $display("[TB] debounce");
        applyStimulus(4'b1110, 1'b1, 1'b1, 3);
        applyStimulus(4'b1111, 1'b1, 1'b1, 1);
        applyStimulus(4'b1110, 1'b1, 1'b1, 6);
        check_value("db_no_glitch_cmd", {3'b000, cmd_valid}, 4'b0000);
        tick();
        check_value("db_latency_dir", cmd_dir, 4'b0001);
        tick();
        check_value("db_single_pulse", {3'b000, cmd_valid}, 4'b0000);
        applyStimulus(4'b1111, 1'b1, 1'b1, 20);

        // Auto-repeat pulse count over the hold
        $display("[TB] auto-repeat");
        pulses = 0;
        mov_raw = 4'b1101;
        for (int i = 0; i < 66; i++) begin
            tick();
            if (cmd_valid) pulses++;
        end
`ifdef REPEAT_EN
        check_value("repeat_count", 4'(pulses), 4'd6);
`else
        check_value("repeat_count", 4'(pulses), 4'd1);
`endif
        applyStimulus(4'b1111, 1'b1, 1'b1, 20);

        // Chord rejection and release to a single key
        $display("[TB] chord");
        applyStimulus(4'b1110, 1'b1, 1'b1, 10);
        applyStimulus(4'b1100, 1'b1, 1'b1, 30);
        applyStimulus(4'b1101, 1'b1, 1'b1, 12);
        applyStimulus(4'b1111, 1'b1, 1'b1, 20);

        // Backpressure: held command, events dropped, one-cycle accept
        $display("[TB] backpressure");
        applyStimulus(4'b0111, 1'b1, 1'b0, 40);
        check_value("bp_hold_dir", cmd_dir, 4'b1000);
        applyStimulus(4'b0111, 1'b1, 1'b1, 1);
        check_value("bp_accept_valid", {3'b000, cmd_valid}, 4'b0000);
        applyStimulus(4'b0111, 1'b1, 1'b0, 5);
        applyStimulus(4'b1111, 1'b1, 1'b1, 20);

        // en gating: held key with en low, then raised
        $display("[TB] en gating");
        applyStimulus(4'b1110, 1'b0, 1'b1, 30);
        check_value("en_pressed", pressed, 4'b0001);
        applyStimulus(4'b1110, 1'b1, 1'b1, 1);
        check_value("en_no_immediate", {3'b000, cmd_valid}, 4'b0000);
        applyStimulus(4'b1110, 1'b1, 1'b1, 30);
        applyStimulus(4'b1111, 1'b1, 1'b1, 20);

        // Random button traffic with random en and ready
        $display("[TB] random traffic");
        for (int s = 0; s < 80; s++) begin
            case ($urandom_range(0, 9))
                0, 1:    rnd_raw = 4'b1111;
                2, 3:    rnd_raw = 4'($urandom_range(0, 15));
                default: rnd_raw = ~(4'b0001 << $urandom_range(0, 3));
            endcase
            rnd_len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                  : int'($urandom_range(5, 45));
            mov_raw = rnd_raw;
            en = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < rnd_len; i++) begin
                cmd_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
